// File: rtl/reg_file_2w2r_sb.sv
// Dual-write, dual-read integer register file with a per-register busy
// scoreboard. Port A is ALU writeback and port B is load writeback. When both
// ports write the same register in one cycle, B wins. Reads are combinational,
// with optional same-cycle forwarding of write data.

// One combinational read port. It resolves the zero register, write
// forwarding and the busy mask for a single address.
module reg_file_2w2r_sb_rdport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                        rst_n_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [NREGS-1:0][XLEN-1:0]  regs_i,
  input  logic [NREGS-1:0]            busy_i,
  input  logic                        wa_en_i,
  input  logic [AW-1:0]               wa_addr_i,
  input  logic [XLEN-1:0]             wa_data_i,
  input  logic                        wb_en_i,
  input  logic [AW-1:0]               wb_addr_i,
  input  logic [XLEN-1:0]             wb_data_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        busy_o
);
  logic zero_hit, wa_fwd, wb_fwd;

  assign zero_hit = (ZERO_REG != 0) && (addr_i == '0);
  assign wa_fwd   = (BYPASS != 0) && wa_en_i && (wa_addr_i == addr_i);
  assign wb_fwd   = (BYPASS != 0) && wb_en_i && (wb_addr_i == addr_i);

  // Later overrides win: stored value, then A, then B, then zero/reset.
  // A forwarded write also resolves the pending producer, so busy is masked.
  always_comb begin
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
    if (wa_fwd) begin
      data_o = wa_data_i;
      busy_o = 1'b0;
    end
    if (wb_fwd) begin
      data_o = wb_data_i;
      busy_o = 1'b0;
    end
    if (zero_hit || !rst_n_i) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end
endmodule

module reg_file_2w2r_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush
);
  localparam int NRD = 2;

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NRD-1:0][XLEN-1:0]   rd_data;
  logic [NRD-1:0]             rd_busy;

  // Per-entry next state. A write clears busy, but a same-cycle issue sets it
  // again because the newer producer is still outstanding. Flush clears every
  // busy bit and drops the issue, but it does not cancel writes.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      logic live, wa_hit, wb_hit, set;
      live   = !((ZERO_REG != 0) && (i == 0));
      wa_hit = live && wa_en && (wa_addr == AW'(i));
      wb_hit = live && wb_en && (wb_addr == AW'(i));
      set    = live && iss_en && (iss_rd == AW'(i)) && !flush;
      if (wb_hit)      regs_d[i] = wb_data;
      else if (wa_hit) regs_d[i] = wa_data;
      if (flush)                 busy_d[i] = 1'b0;
      else if (set)              busy_d[i] = 1'b1;
      else if (wa_hit || wb_hit) busy_d[i] = 1'b0;
    end
  end

  // Storage and scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign rd_addr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    reg_file_2w2r_sb_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .rst_n_i  (rst_n),
      .addr_i   (rd_addr[p]),
      .regs_i   (regs_q),
      .busy_i   (busy_q),
      .wa_en_i  (wa_en),
      .wa_addr_i(wa_addr),
      .wa_data_i(wa_data),
      .wb_en_i  (wb_en),
      .wb_addr_i(wb_addr),
      .wb_data_i(wb_data),
      .data_o   (rd_data[p]),
      .busy_o   (rd_busy[p])
    );
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
  assign rs1_busy = rd_busy[0];
  assign rs2_busy = rd_busy[1];

`ifndef SYNTHESIS
  // Addresses at or above NREGS can only occur when NREGS < 2^AW. They are illegal.
  a_aw_match: assert property (@(posedge clk) AW == $clog2(NREGS));
  a_rs1_rng:  assert property (@(posedge clk) disable iff (!rst_n) int'(rs1_addr) < NREGS);
  a_rs2_rng:  assert property (@(posedge clk) disable iff (!rst_n) int'(rs2_addr) < NREGS);
  a_wa_rng:   assert property (@(posedge clk) disable iff (!rst_n) wa_en  |-> int'(wa_addr) < NREGS);
  a_wb_rng:   assert property (@(posedge clk) disable iff (!rst_n) wb_en  |-> int'(wb_addr) < NREGS);
  a_iss_rng:  assert property (@(posedge clk) disable iff (!rst_n) iss_en |-> int'(iss_rd)  < NREGS);
`endif
endmodule

// File: tb/tb_reg_file_2w2r_sb.sv
// Bench for reg_file_2w2r_sb. Two instances share all inputs: one with
// forwarding enabled and one with it disabled. Expected values go into a queue
// when stimulus is applied. They are then popped in order against the sampled outputs.
module tb_reg_file_2w2r_sb;
  logic        clk, rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wa_addr, wb_addr, iss_rd;
  logic [31:0] wa_data, wb_data;
  logic        wa_en, wb_en, iss_en, flush;
  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic        rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;

  typedef struct { string name; logic [31:0] val; } exp_t;
  exp_t        sb[$];
  logic [31:0] obs[$];
  int          checks = 0;
  int          passed = 0;

  reg_file_2w2r_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush)
  );

  reg_file_2w2r_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs1_data(nb_rs1_data), .rs1_busy(nb_rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(nb_rs2_data), .rs2_busy(nb_rs2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    iss_en = 0; iss_rd = 0; flush = 0;
  endtask

  // Advance one edge and leave inputs changing away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input logic [31:0] v, input logic [31:0] o);
    sb.push_back('{name, v});
    obs.push_back(o);
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] o;
    idle(); wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
    cyc(); idle(); rs1_addr = 5; #1;
    expect_v("x5_written", 32'hDEADBEEF, rs1_data);
    rst_n = 0; #1;
    expect_v("rst_async_data", 32'h0, rs1_data);
    expect_v("rst_async_busy", 32'h0, {31'h0, rs1_busy});
    cyc(); rst_n = 1;
    wa_en = 1; wa_addr = 0; wa_data = 32'h1234; iss_en = 1; iss_rd = 0; rs1_addr = 0; #1;
    expect_v("x0_wr_cycle_data", 32'h0, rs1_data);
    expect_v("x0_wr_cycle_busy", 32'h0, {31'h0, rs1_busy});
    cyc(); idle(); #1;
    expect_v("x0_after_data", 32'h0, rs1_data);
    expect_v("x0_after_busy", 32'h0, {31'h0, rs1_busy});
    rs1_addr = 5; #1;
    expect_v("x5_cleared", 32'h0, rs1_data);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_dual_write();
    exp_t e; logic [31:0] o;
    idle();
    wa_en = 1; wa_addr = 3; wa_data = 32'h11111111;
    wb_en = 1; wb_addr = 4; wb_data = 32'h22222222;
    cyc(); idle(); rs1_addr = 3; rs2_addr = 4; #1;
    expect_v("dual_rs1_x3", 32'h11111111, rs1_data);
    expect_v("dual_rs2_x4", 32'h22222222, rs2_data);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_conflict_bypass();
    exp_t e; logic [31:0] o;
    idle(); wa_en = 1; wa_addr = 7; wa_data = 32'h12345678;
    cyc(); idle();
    wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA0000;
    wb_en = 1; wb_addr = 7; wb_data = 32'h0000BBBB;
    rs1_addr = 7; rs2_addr = 7; #1;
    expect_v("conf_byp_rs1", 32'h0000BBBB, rs1_data);
    expect_v("conf_byp_rs2", 32'h0000BBBB, rs2_data);
    expect_v("conf_nobyp_old", 32'h12345678, nb_rs1_data);
    cyc(); idle(); #1;
    expect_v("conf_stored", 32'h0000BBBB, rs1_data);
    expect_v("conf_stored_nb", 32'h0000BBBB, nb_rs2_data);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_scoreboard();
    exp_t e; logic [31:0] o;
    idle(); iss_en = 1; iss_rd = 9; rs2_addr = 9; #1;
    expect_v("sb_issue_cycle", 32'h0, {31'h0, rs2_busy});
    cyc(); idle(); #1;
    expect_v("sb_busy_next", 32'h1, {31'h0, rs2_busy});
    wa_en = 1; wa_addr = 9; wa_data = 32'h55; #1;
    expect_v("sb_wb_busy_masked", 32'h0, {31'h0, rs2_busy});
    expect_v("sb_wb_data_fwd", 32'h55, rs2_data);
    expect_v("sb_nobyp_busy", 32'h1, {31'h0, nb_rs2_busy});
    cyc(); idle(); #1;
    expect_v("sb_clear_after", 32'h0, {31'h0, rs2_busy});
    expect_v("sb_data_after", 32'h55, rs2_data);
    cyc(); #1;
    expect_v("sb_stays_clear", 32'h0, {31'h0, nb_rs2_busy});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_set_clear();
    exp_t e; logic [31:0] o;
    idle(); iss_en = 1; iss_rd = 12;
    cyc(); idle();
    iss_en = 1; iss_rd = 12; wb_en = 1; wb_addr = 12; wb_data = 32'h77;
    cyc(); idle(); rs1_addr = 12; #1;
    expect_v("setclr_busy", 32'h1, {31'h0, rs1_busy});
    expect_v("setclr_data", 32'h77, rs1_data);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  task automatic test_flush();
    exp_t e; logic [31:0] o;
    idle(); iss_en = 1; iss_rd = 1; cyc();
    iss_rd = 2; cyc();
    iss_rd = 31; cyc(); idle();
    rs1_addr = 31; rs2_addr = 2; #1;
    expect_v("fl_pre_x31", 32'h1, {31'h0, rs1_busy});
    expect_v("fl_pre_x2", 32'h1, {31'h0, rs2_busy});
    flush = 1; iss_en = 1; iss_rd = 6; wa_en = 1; wa_addr = 1; wa_data = 32'h99;
    cyc(); idle(); rs1_addr = 1; rs2_addr = 2; #1;
    expect_v("fl_x1_data", 32'h99, rs1_data);
    expect_v("fl_x1_busy", 32'h0, {31'h0, rs1_busy});
    expect_v("fl_x2_busy", 32'h0, {31'h0, rs2_busy});
    rs1_addr = 31; rs2_addr = 6; #1;
    expect_v("fl_x31_busy", 32'h0, {31'h0, rs1_busy});
    expect_v("fl_x6_busy", 32'h0, {31'h0, rs2_busy});
    rs1_addr = 12; #1;
    expect_v("fl_x12_busy", 32'h0, {31'h0, nb_rs1_busy});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      else passed++;
    end
  endtask

  // Random traffic on a few registers, so port collisions happen often. A
  // small reference model of the registers and the busy bits predicts every read.
  task automatic test_random();
    exp_t e; logic [31:0] o;
    logic [31:0] mregs [32];
    logic        mbusy [32];
    logic [4:0]  a;
    logic [31:0] ed;
    logic        eb;
    idle(); rst_n = 0; #1; rst_n = 1;
    for (int i = 0; i < 32; i++) begin mregs[i] = 0; mbusy[i] = 0; end
    for (int n = 0; n < 200; n++) begin
      wa_en = 1'($urandom); wa_addr = 5'($urandom_range(0, 7)); wa_data = $urandom;
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      iss_en = 1'($urandom); iss_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
      rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? rs1_addr : rs2_addr;
        ed = mregs[a]; eb = mbusy[a];
        if (wa_en && wa_addr == a) begin ed = wa_data; eb = 0; end
        if (wb_en && wb_addr == a) begin ed = wb_data; eb = 0; end
        if (a == 0) begin ed = 0; eb = 0; end
        sb.push_back('{$sformatf("rnd%0d_rs%0d_data", n, p + 1), ed});
        sb.push_back('{$sformatf("rnd%0d_rs%0d_busy", n, p + 1), {31'h0, eb}});
      end
      obs.push_back(rs1_data); obs.push_back({31'h0, rs1_busy});
      obs.push_back(rs2_data); obs.push_back({31'h0, rs2_busy});
      while (sb.size() > 0) begin
        e = sb.pop_front(); o = obs.pop_front(); checks++;
        if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
        else passed++;
      end
      if (wa_en && wa_addr != 0) mregs[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
      end else begin
        if (wa_en) mbusy[wa_addr] = 0;
        if (wb_en) mbusy[wb_addr] = 0;
        if (iss_en && iss_rd != 0) mbusy[iss_rd] = 1;
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    exp_t e; logic [31:0] o;
    idle(); rs1_addr = 0; rs2_addr = 0; rst_n = 0;
    #2;
    rs1_addr = 9; rs2_addr = 17;
    #1;
    expect_v("por_rs1_data", 32'h0, rs1_data);
    expect_v("por_rs2_busy", 32'h0, {31'h0, rs2_busy});
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.val) $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      else passed++;
    end
    #9 rst_n = 1;
    cyc();
    test_reset();
    test_dual_write();
    test_conflict_bypass();
    test_scoreboard();
    test_set_clear();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
